branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Closes the loop on the BTB. Carries each fetched instruction's BTB prediction alongside the pipeline to the execute stage.
- At execute, compares the prediction with the real outcome and issues the redirect/flush when they differ.
- Drives the BTB update port: resolved PC, destination PC, branch flag and taken flag.
- Keeps saturating branch and mispredict counters for performance evaluation.

Parameters:
- RESOLVE_DEPTH, 2: number of shadow stages between fetch and the resolve (EX) stage. Legal range is 1..4.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  pipeline hold; the shadow pipeline and resolution are frozen
- ext_flush  in  1  external flush (exception/trap); highest priority
- if_valid  in  1  a fetch is accepted this cycle
- if_PC  in  32  PC of the fetched instruction
- if_BTB_hit  in  1  BTB hit returned for if_PC
- if_BTB_PC  in  32  BTB predicted target
- ex_valid  in  1  a valid instruction is in EX
- ex_PC  in  32  PC of the EX instruction
- ex_is_branch  in  1  the EX instruction is a branch, jal or jalr
- ex_taken  in  1  actual branch outcome
- ex_target  in  32  actual target
- redirect  out  1  one-cycle pulse: fetch restarts at redirect_PC
- redirect_PC  out  32  correct next PC
- flush_out  out  1  kill younger instructions; equals redirect
- upd_PC  out  32  BTB update index PC (BTB resolved_Branch_PC)
- upd_dest  out  32  BTB destination_PC
- upd_is_branch  out  1  BTB is_branch_inst
- upd_taken  out  1  BTB updata_taken
- sync_error  out  1  sticky flag: shadow head PC ≠ ex_PC at a resolve
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (rst=0, async): every shadow entry is invalid, FSM=RUN, and every output is 0.
- Shadow pipeline:
  - RESOLVE_DEPTH entries, each {valid, PC, hit, target}. Entry 0 is loaded from the if_* inputs, with valid=if_valid.
  - When stall=0, entries shift by one each cycle. When stall=1, all entries hold.
  - The head is entry RESOLVE_DEPTH-1.
- Resolve event: ex_valid & !stall & FSM==RUN & !ext_flush.
- At a resolve event:
  - If the head is valid and head.PC ≠ ex_PC, set sync_error; it stays set until reset.
  - Predicted next PC = head.hit ? head.target : ex_PC+4, where the addition wraps mod 2^32.
  - Actual next PC = (ex_is_branch & ex_taken) ? ex_target : ex_PC+4.
  - Mispredict when predicted next PC ≠ actual next PC. This includes a BTB alias hit on a non-branch.
  - An invalid head counts as hit=0.
- Outputs are registered; all of them appear in cycle N+1 for a resolve in cycle N:
  - upd_is_branch = ex_is_branch.
  - upd_taken = ex_is_branch & ex_taken.
  - upd_PC = ex_PC.
  - upd_dest = ex_target.
  - Each upd_* signal is a one-cycle pulse; it is 0 when there is no resolve.
  - branch_cnt increments when ex_is_branch=1. mispred_cnt increments on a mispredict. Both saturate at all-ones and never wrap.
- FSM:
  - RUN → REDIRECT on a mispredict. In that N+1 cycle, redirect=flush_out=1 and redirect_PC = actual next PC.
  - REDIRECT → DRAIN unconditionally. On the same edge every shadow entry is invalidated, except that entry 0 loads the if_* inputs.
  - DRAIN lasts RESOLVE_DEPTH cycles, counted by a down-counter that only decrements when stall=0. No resolves are taken during DRAIN, because wrong-path EX instructions are being squashed. Then DRAIN → RUN.
  - A stall during REDIRECT does not extend the redirect pulse.
- ext_flush:
  - Takes effect on the edge it is sampled: all shadow entries are invalidated, FSM → RUN, and any pending redirect is dropped.
  - redirect and upd_* are 0 in the following cycle.
  - The counters are unaffected.
- A resolve with stall=1 is ignored. The caller holds the resolve until stall drops.

Decomposition:
- Shared package:
  - FSM state enum {RUN, REDIRECT, DRAIN}.
  - Shadow entry struct {valid, PC, hit, target}.
  - Constant PC_INC=4.
- One sub-module, pred_shadow_pipe: the parameterised shift register with stall, flush and head output.

Test Plan:
1. Correct prediction: fetch PC 0x100 with hit=1, target 0x200. Two cycles later EX resolves ex_PC=0x100, taken, target 0x200. Expect: redirect=0; in N+1, upd_taken=1, upd_PC=0x100, upd_dest=0x200; branch_cnt=1, mispred_cnt=0.
2. Cold miss: hit=0, actual taken to 0x340 from PC 0x120. Expect: redirect=1 for one cycle with redirect_PC=0x340; mispred_cnt=1; upd_taken=1; next RESOLVE_DEPTH cycles with ex_valid=1 produce no upd pulses.
3. Alias: non-branch at 0x4100 with hit=1, target 0x80. Expect: redirect_PC=0x4104, upd_is_branch=0, upd_taken=0, mispred_cnt increments, branch_cnt unchanged.
4. Stall: assert stall for 3 cycles while EX holds a mispredicting branch. Expect: no redirect until the cycle after stall drops; shadow contents are unchanged across the stall.
5. ext_flush in the REDIRECT cycle. Expect: FSM=RUN next cycle, all shadow entries invalid, redirect=0, and a subsequent resolve is accepted immediately.
6. Edge cases:
   - PC 0xFFFFFFFC not-taken with hit=0: predicted = actual = 0x00000000 (wrap), no redirect.
   - Preload mispred_cnt to all-ones and mispredict: the count holds.
   - Shadow head PC 0x10 vs ex_PC 0x14: sync_error=1 and remains set.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: FSM states, shadow entry layout
// and sequential-PC helper.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } bru_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] target;
  } shadow_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

  // Fall-through PC; wraps mod 2^32 by construction of the 32-bit sum.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/update bundle of the branch resolve unit; the pipeline side
// is master, the resolve unit is slave.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             ext_flush;
  logic             if_valid;
  logic [31:0]      if_PC;
  logic             if_BTB_hit;
  logic [31:0]      if_BTB_PC;
  logic             ex_valid;
  logic [31:0]      ex_PC;
  logic             ex_is_branch;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             redirect;
  logic [31:0]      redirect_PC;
  logic             flush_out;
  logic [31:0]      upd_PC;
  logic [31:0]      upd_dest;
  logic             upd_is_branch;
  logic             upd_taken;
  logic             sync_error;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall, ext_flush,
    output if_valid, if_PC, if_BTB_hit, if_BTB_PC,
    output ex_valid, ex_PC, ex_is_branch, ex_taken, ex_target,
    input  redirect, redirect_PC, flush_out,
    input  upd_PC, upd_dest, upd_is_branch, upd_taken,
    input  sync_error, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall, ext_flush,
    input  if_valid, if_PC, if_BTB_hit, if_BTB_PC,
    input  ex_valid, ex_PC, ex_is_branch, ex_taken, ex_target,
    output redirect, redirect_PC, flush_out,
    output upd_PC, upd_dest, upd_is_branch, upd_taken,
    output sync_error, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_resolve_unit_pred_shadow_pipe.sv
// Shift register carrying BTB predictions from fetch to EX; flush clears all,
// squash clears all but still captures the current fetch into entry 0.
module pred_shadow_pipe
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          squash,
  input  shadow_entry_t in_entry,
  output shadow_entry_t head
);

  shadow_entry_t sh [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sh[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) sh[i] <= '0;
    end else if (squash) begin
      // Squash ignores stall: the redirect edge must always clear wrong-path state.
      sh[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) sh[i] <= '0;
    end else if (!stall) begin
      sh[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) sh[i] <= sh[i-1];
    end
  end

  assign head = sh[DEPTH-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares the carried BTB prediction with the EX outcome, issues redirects,
// drives BTB updates and keeps saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int RESOLVE_DEPTH = 2,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam int DW = $clog2(RESOLVE_DEPTH + 1);

  bru_state_e       state;
  logic [DW-1:0]    drain_cnt;
  shadow_entry_t    in_entry;
  shadow_entry_t    head;

  logic             resolve;
  logic             mispredict;
  logic [31:0]      seq_pc;
  logic [31:0]      pred_pc;
  logic [31:0]      actual_pc;
  logic             actual_taken;

  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      upd_pc_q;
  logic [31:0]      upd_dest_q;
  logic             upd_is_branch_q;
  logic             upd_taken_q;
  logic             sync_error_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  assign in_entry = '{valid:  bus.if_valid,
                      pc:     bus.if_PC,
                      hit:    bus.if_BTB_hit,
                      target: bus.if_BTB_PC};

  pred_shadow_pipe #(
    .DEPTH (RESOLVE_DEPTH)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall),
    .flush    (bus.ext_flush),
    .squash   (state == REDIRECT),
    .in_entry (in_entry),
    .head     (head)
  );

  assign resolve      = bus.ex_valid & ~bus.stall & (state == RUN) & ~bus.ext_flush;
  assign seq_pc       = next_seq_pc(bus.ex_PC);
  assign actual_taken = bus.ex_is_branch & bus.ex_taken;
  // An invalid head behaves as a BTB miss.
  assign pred_pc      = (head.valid & head.hit) ? head.target : seq_pc;
  assign actual_pc    = actual_taken ? bus.ex_target : seq_pc;
  assign mispredict   = resolve & (pred_pc != actual_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      drain_cnt       <= '0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= '0;
      upd_pc_q        <= '0;
      upd_dest_q      <= '0;
      upd_is_branch_q <= 1'b0;
      upd_taken_q     <= 1'b0;
      sync_error_q    <= 1'b0;
      branch_cnt_q    <= '0;
      mispred_cnt_q   <= '0;
    end else begin
      redirect_q      <= mispredict;
      redirect_pc_q   <= mispredict ? actual_pc : '0;
      upd_pc_q        <= resolve ? bus.ex_PC : '0;
      upd_dest_q      <= resolve ? bus.ex_target : '0;
      upd_is_branch_q <= resolve & bus.ex_is_branch;
      upd_taken_q     <= resolve & actual_taken;

      if (resolve && head.valid && (head.pc != bus.ex_PC))
        sync_error_q <= 1'b1;
      if (resolve && bus.ex_is_branch && (branch_cnt_q != '1))
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);

      if (bus.ext_flush) begin
        state     <= RUN;
        drain_cnt <= '0;
      end else begin
        case (state)
          RUN: begin
            if (mispredict) state <= REDIRECT;
          end
          REDIRECT: begin
            state     <= DRAIN;
            drain_cnt <= DW'(RESOLVE_DEPTH);
          end
          DRAIN: begin
            // Wrong-path EX slots are skipped only on cycles the pipe advances.
            if (!bus.stall) begin
              drain_cnt <= drain_cnt - DW'(1);
              if (drain_cnt <= DW'(1)) state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign bus.redirect      = redirect_q;
  assign bus.flush_out     = redirect_q;
  assign bus.redirect_PC   = redirect_pc_q;
  assign bus.upd_PC        = upd_pc_q;
  assign bus.upd_dest      = upd_dest_q;
  assign bus.upd_is_branch = upd_is_branch_q;
  assign bus.upd_taken     = upd_taken_q;
  assign bus.sync_error    = sync_error_q;
  assign bus.branch_cnt    = branch_cnt_q;
  assign bus.mispred_cnt   = mispred_cnt_q;

endmodule
